// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I MEM stage: word RAM, configurable wait states, lane-merged stores.
// Optional misalignment faulting is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW+1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_funct3;
    logic          lat_write;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW+1:0] op_addr;
    logic [31:0]   op_wdata;
    logic [2:0]    op_funct3;
    logic          op_write;
    logic [AW-1:0] op_idx;
    logic          do_access;
    logic          fault;
    logic [3:0]    byte_en;
    logic [31:0]   lane_data;
    logic [31:0]   rd_word;
    logic [31:0]   merged;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_data;
    logic          unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    assign req_ready = (state == IDLE) && req_valid;
    assign stall     = req_ready || (state == WAIT);

    // With zero wait states the access happens on the accept edge, straight from the inputs.
    always_comb begin
        op_addr   = lat_addr;
        op_wdata  = lat_wdata;
        op_funct3 = lat_funct3;
        op_write  = lat_write;
        if (state == IDLE) begin
            op_addr   = req_addr[AW+1:0];
            op_wdata  = req_wdata;
            op_funct3 = req_funct3;
            op_write  = req_write;
        end
    end

    assign op_idx    = op_addr[AW+1:2];
    assign do_access = (WAIT_CYCLES == 0) ? req_ready : ((state == WAIT) && (wait_cnt == 4'd1));
    assign rd_word   = mem[op_idx];

    always_comb begin
        byte_en   = 4'b1111;
        lane_data = op_wdata;
        fault     = 1'b0;
        case (op_funct3)
            3'b000, 3'b100: begin
                byte_en   = 4'b0001 << op_addr[1:0];
                lane_data = {4{op_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                byte_en   = op_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{op_wdata[15:0]}};
            end
            default: ;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        case (op_funct3)
            3'b001, 3'b101:         fault = op_addr[0];
            3'b010:                 fault = |op_addr[1:0];
            3'b011, 3'b110, 3'b111: fault = 1'b1;
            default:                fault = 1'b0;
        endcase
`endif
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            merged[8*i +: 8] = byte_en[i] ? lane_data[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    assign lane_b = rd_word[{op_addr[1:0], 3'b000} +: 8];
    assign lane_h = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (op_funct3)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_data = {24'd0, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_data = {16'd0, lane_h};
            default: load_data = rd_word;
        endcase
    end

    // RAM is deliberately not reset; an aborted store never reaches do_access.
    always_ff @(posedge clock) begin
        if (do_access && op_write && !fault) begin
            mem[op_idx] <= merged;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
            lat_write  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (do_access) begin
                rsp_error <= fault;
                rsp_rdata <= (op_write || fault) ? '0 : load_data;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr   <= req_addr[AW+1:0];
                        lat_wdata  <= req_wdata;
                        lat_funct3 <= req_funct3;
                        lat_write  <= req_write;
                        wait_cnt   <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized accesses against a byte-level model.
module tb_dmem_responder;
    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        v2, v0;
    logic        rdy2, stall2, rv2, err2;
    logic [31:0] rd2;
    logic        rdy0, stall0, rv0, err0;
    logic [31:0] rd0;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .req_valid(v2), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rdy2), .stall(stall2), .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_error(err2)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .req_valid(v0), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(rdy0), .stall(stall0), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_error(err0)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  ref_mem [1024];
    bit          trap_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Byte-addressed view of the RAM (1 KiB, so addresses wrap at 0x400).
    function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int unsigned a, size, base;
        logic [31:0] v;
        a = addr % 1024;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        base  = a - (a % size);
        err   = trap_en && ((a % size != 0) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        rdata = '0;
        if (err) return;
        if (wr) begin
            for (int k = 0; k < int'(size); k++) ref_mem[base + k] = wdata[8*k +: 8];
        end else begin
            v = '0;
            for (int k = 0; k < int'(size); k++) v = v | (32'(ref_mem[base + k]) << (8*k));
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
            rdata = v;
        end
    endfunction

    task automatic access(input string tag, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        logic [31:0] exp_d;
        logic        exp_e;
        int unsigned lat, stalls;
        model(wr, f3, addr, wdata, exp_d, exp_e);
        @(negedge clock);
        check({tag, "/idle_valid"}, 32'(rv2), 32'd0);
        v2 = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        check({tag, "/ready"}, 32'(rdy2), 32'd1);
        stalls = stall2 ? 1 : 0;
        @(posedge clock); #1;
        v2 = 1'b0; req_write = $urandom_range(0, 1); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        while (lat < 20) begin
            @(negedge clock);
            lat++;
            if (rv2) break;
            if (stall2) stalls++;
        end
        check({tag, "/latency"}, lat, 32'd3);
        check({tag, "/stall_cycles"}, stalls, 32'd3);
        check({tag, "/resp_stall"}, 32'(stall2), 32'd0);
        check({tag, "/rdata"}, rd2, exp_d);
        check({tag, "/error"}, 32'(err2), 32'(exp_e));
        rdata = rd2;
        err   = err2;
    endtask

    initial begin
        logic [31:0] d, exp_d;
        logic        e, exp_e, saw;
        trap_en = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        trap_en = 1'b1;
`endif
        reset = 1'b0; v2 = 1'b0; v0 = 1'b0;
        req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clock);
        check("rst/ready", 32'(rdy2), 32'd0);
        check("rst/stall", 32'(stall2), 32'd0);
        check("rst/valid", 32'(rv2), 32'd0);
        check("rst/rdata", rd2, 32'd0);
        check("rst/error", 32'(err2), 32'd0);
        reset = 1'b1;

        access("sw_dead", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e);
        access("lw_dead", 1'b0, 3'b010, 32'h10, 32'h0, d, e);
        check("roundtrip", d, 32'hDEADBEEF);

        access("sw_base", 1'b1, 3'b010, 32'h10, 32'h11223344, d, e);
        access("sb_13",   1'b1, 3'b000, 32'h13, 32'h00000080, d, e);
        access("sh_10",   1'b1, 3'b001, 32'h10, 32'h0000ABCD, d, e);
        access("lw_10",   1'b0, 3'b010, 32'h10, 32'h0, d, e);
        check("merge_lw", d, 32'h8022ABCD);
        access("lb_13",   1'b0, 3'b000, 32'h13, 32'h0, d, e);
        check("merge_lb", d, 32'hFFFFFF80);
        access("lbu_13",  1'b0, 3'b100, 32'h13, 32'h0, d, e);
        check("merge_lbu", d, 32'h00000080);
        access("lh_12",   1'b0, 3'b001, 32'h12, 32'h0, d, e);
        check("merge_lh", d, 32'hFFFF8022);

        access("sw_400", 1'b1, 3'b010, 32'h400, 32'h5A5A5A5A, d, e);
        access("lw_0",   1'b0, 3'b010, 32'h0, 32'h0, d, e);
        check("wrap", d, 32'h5A5A5A5A);

        access("sw_20",  1'b1, 3'b010, 32'h20, 32'h0BADF00D, d, e);
        access("lw_20a", 1'b0, 3'b010, 32'h20, 32'h0, d, e);
        @(negedge clock);
        v2 = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
        @(posedge clock); #1;
        v2 = 1'b0;
        @(negedge clock);
        check("midrst/wait_stall", 32'(stall2), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst/ready", 32'(rdy2), 32'd0);
        check("midrst/stall", 32'(stall2), 32'd0);
        check("midrst/valid", 32'(rv2), 32'd0);
        check("midrst/rdata", rd2, 32'd0);
        check("midrst/error", 32'(err2), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (rv2) saw = 1'b1;
        end
        check("midrst/no_pulse", 32'(saw), 32'd0);
        access("lw_20b", 1'b0, 3'b010, 32'h20, 32'h0, d, e);
        check("midrst/kept", d, 32'h0BADF00D);

        access("sw_mis", 1'b1, 3'b010, 32'h20, 32'h12345678, d, e);
        access("lw_22",  1'b0, 3'b010, 32'h22, 32'h0, d, e);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("misalign/data", d, 32'h0);
        check("misalign/err", 32'(e), 32'd1);
`else
        check("misalign/data", d, 32'h12345678);
        check("misalign/err", 32'(e), 32'd0);
`endif

        // Zero wait states with req_valid held: accept, respond, accept, ...
        @(negedge clock);
        v0 = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("zw/ready", 32'(rdy0), 32'((i % 2) == 0));
            check("zw/stall", 32'(stall0), 32'((i % 2) == 0));
            check("zw/valid", 32'(rv0), 32'((i % 2) == 1));
            if (i % 2 == 1) check("zw/rdata", rd0, (i == 1) ? 32'h0 : 32'hCAFEF00D);
            @(posedge clock); #1;
            req_write = 1'b0;
            @(negedge clock);
        end
        v0 = 1'b0;

        for (int w = 0; w < 16; w++) access("init", 1'b1, 3'b010, 32'(w * 4), $urandom, d, e);
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
            access("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, d, e);
        end
        exp_d = '0; exp_e = 1'b0;
        model(1'b0, 3'b010, 32'h0, 32'h0, exp_d, exp_e);
        access("final_lw0", 1'b0, 3'b010, 32'h0, 32'h0, d, e);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
